// File: rtl/wave_meas_pkg.sv
// Shared types and defaults for the waveform measurement engine.
package wave_meas_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeas,
      StDone
   } state_e;

   localparam int unsigned MID_DEF     = 567;
   localparam int unsigned HYST_DEF    = 8;
   localparam int unsigned FLOOR_DEF   = 255;
   localparam int unsigned MIN_PER_DEF = 100000;

   // Clamp a peak-to-peak span to the largest value an amp_w-bit output can hold.
   function automatic logic [31:0] sat_amp(input logic [31:0] diff, input int unsigned amp_w);
      logic [31:0] lim;
      lim = (amp_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << amp_w) - 32'd1);
      return (diff > lim) ? lim : diff;
   endfunction

endpackage

// File: rtl/wave_xing_det.sv
// Registered sample stage with hysteretic falling-crossing detection about MID.
module wave_xing_det #(
   parameter int unsigned DW   = 16,
   parameter int unsigned MID  = 567,
   parameter int unsigned HYST = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic [DW-1:0] smpl_i,
   input  logic          smpl_vld_i,
   output logic [DW-1:0] smpl_o,
   output logic          acc_o,
   output logic          xing_o
);

   localparam logic [DW-1:0] MidV  = DW'(MID);
   localparam logic [DW-1:0] ArmV  = DW'(MID + HYST);

   logic [DW-1:0] smpl_q;
   logic          acc_q;
   logic          above_q;

   assign xing_o = acc_q & above_q & (smpl_q <= MidV);
   assign smpl_o = smpl_q;
   assign acc_o  = acc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         smpl_q  <= '0;
         acc_q   <= 1'b0;
         above_q <= 1'b0;
      end else if (clr_i) begin
         smpl_q  <= '0;
         acc_q   <= 1'b0;
         above_q <= 1'b0;
      end else begin
         acc_q <= smpl_vld_i;
         if (smpl_vld_i) smpl_q <= smpl_i;
         // above only moves on a freshly accepted sample
         if (acc_q) begin
            if (smpl_q > ArmV)  above_q <= 1'b1;
            else if (xing_o)    above_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/wave_meas_core.sv
// Period and peak-to-peak measurement between qualified falling crossings of MID.
module wave_meas_core
   import wave_meas_pkg::*;
#(
   parameter int unsigned DW      = 16,
   parameter int unsigned CNT_W   = 22,
   parameter int unsigned AMP_W   = 12,
   parameter int unsigned MID     = MID_DEF,
   parameter int unsigned HYST    = HYST_DEF,
   parameter int unsigned FLOOR   = FLOOR_DEF,
   parameter int unsigned MIN_PER = MIN_PER_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             start_i,
   input  logic             cont_i,
   input  logic [DW-1:0]    smpl_i,
   input  logic             smpl_vld_i,
   output logic [CNT_W-1:0] freq_o,
   output logic [AMP_W-1:0] amp_o,
   output logic             meas_vld_o,
   output logic             busy_o,
   output logic             timeout_o
);

   localparam logic [DW-1:0]    MidV   = DW'(MID);
   localparam logic [DW-1:0]    FloorV = DW'(FLOOR);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [DW-1:0]    smpl_q;
   logic             smpl_acc;
   logic             xing;
   logic [DW-1:0]    span;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DW-1:0]    max_q;
   logic [DW-1:0]    min_q;
   logic [CNT_W-1:0] freq_q;
   logic [AMP_W-1:0] amp_q;
   logic             meas_vld_q;
   logic             timeout_q;

   wave_xing_det #(
      .DW   (DW),
      .MID  (MID),
      .HYST (HYST)
   ) u_xing_det (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_i),
      .smpl_i     (smpl_i),
      .smpl_vld_i (smpl_vld_i),
      .smpl_o     (smpl_q),
      .acc_o      (smpl_acc),
      .xing_o     (xing)
   );

   assign span = max_q - min_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         max_q      <= MidV;
         min_q      <= MidV;
         freq_q     <= '0;
         amp_q      <= '0;
         meas_vld_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (clr_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         max_q      <= MidV;
         min_q      <= MidV;
         freq_q     <= '0;
         amp_q      <= '0;
         meas_vld_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         meas_vld_q <= 1'b0;
         // tracker updates are overridden below wherever a new period begins
         if (smpl_acc) begin
            if (smpl_q > max_q) max_q <= smpl_q;
            if ((smpl_q < min_q) && (smpl_q > FloorV)) min_q <= smpl_q;
         end
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q   <= StArm;
                  cnt_q     <= '0;
                  timeout_q <= 1'b0;
                  max_q     <= MidV;
                  min_q     <= MidV;
               end
            end
            StArm, StMeas: begin
               if (cnt_q == CntMax) begin
                  state_q    <= StIdle;
                  timeout_q  <= 1'b1;
                  freq_q     <= '1;
                  amp_q      <= '0;
                  meas_vld_q <= 1'b1;
               end else if (xing && (state_q == StArm)) begin
                  state_q <= StMeas;
                  cnt_q   <= '0;
                  max_q   <= MidV;
                  min_q   <= MidV;
               end else if (xing && (32'(cnt_q) >= MIN_PER)) begin
                  freq_q     <= cnt_q + 1'b1;
                  amp_q      <= AMP_W'(sat_amp(32'(span), AMP_W));
                  meas_vld_q <= 1'b1;
                  cnt_q      <= '0;
                  max_q      <= MidV;
                  min_q      <= MidV;
                  if (!cont_i) state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign freq_o     = freq_q;
   assign amp_o      = amp_q;
   assign meas_vld_o = meas_vld_q;
   assign busy_o     = (state_q != StIdle);
   assign timeout_o  = timeout_q;

endmodule
